// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse-width measurement path.
// Holds the default measured width, FSM state encoding and result sizing.
// No logic; imported by the interface, FIFO and top.
package pulse_meas_pkg;

  // Default width of a measured value; counter saturates at 2^W-1.
  localparam int PW_DEFAULT = 6;

  // Measurement FSM: waiting for a high run, or inside one.
  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  // A queued result is {width, ovf}.
  function automatic int res_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/pulse_meas_if.sv
// Result stream of the pulse meter: valid/ready with width and overflow flag.
// The producer holds width/ovf stable while valid is high and ready is low.
// master = meter side, slave = consumer side.
interface pulse_meas_if
  import pulse_meas_pkg::*;
#(
  parameter int WIDTH = PW_DEFAULT
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_width;
  logic             out_ovf;

  modport master (output out_valid, output out_width, output out_ovf, input out_ready);
  modport slave  (input out_valid, input out_width, input out_ovf, output out_ready);
endinterface

// File: rtl/pulse_meas_fifo.sv
// Generic first-word-fall-through synchronous FIFO, 2^AW entries of DW bits.
// Latency: a push at edge t is visible at head (empty=0) right after edge t.
// Backpressure: a push while full is accepted only if a pop happens the same cycle.
module pulse_meas_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_meas.sv
// Measures the high width of each strobe run, filters glitches, queues {width, ovf}.
// Latency: result visible at the head one cycle after the run's first low sample.
// Backpressure: results arriving at a full FIFO without a same-cycle pop are dropped and counted.
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int WIDTH      = PW_DEFAULT,
  parameter int MIN_WIDTH  = 1,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  input  logic         clear_stats,
  pulse_meas_if.master res,
  output logic         busy,
  output logic [7:0]   drop_cnt,
  output logic [7:0]   glitch_cnt,
  output logic         drop_sticky
);
  localparam int               RW      = res_w(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             run_end;
  logic             long_enough;
  logic             push_req, glitch, drop, push, pop;
  logic             fifo_full, fifo_empty;
  logic [RW-1:0]    head;

  // FSM, width counter and overflow flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next-state: start a run on a high sample, count while high, end on first low sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    run_end   = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_nxt = HIGH;
          cnt_nxt   = {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_nxt   = 1'b0;
        end
      end
      HIGH: begin
        if (pulse_in) begin
          if (cnt == CNT_MAX) ovf_nxt = 1'b1;
          else                cnt_nxt = cnt + 1'b1;
        end else begin
          run_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state == HIGH);
  assign long_enough = ({1'b0, cnt} >= MIN_W);
  assign push_req    = run_end & long_enough;
  assign glitch      = run_end & ~long_enough;
  assign pop         = res.out_valid & res.out_ready;
  assign drop        = push_req & fifo_full & ~pop;
  assign push        = push_req & ~drop;

  pulse_meas_fifo #(
    .DW (RW),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({cnt, ovf}),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head fields are masked while empty so an idle output reads zero.
  assign res.out_valid = ~fifo_empty;
  assign res.out_width = fifo_empty ? '0 : head[RW-1:1];
  assign res.out_ovf   = fifo_empty ? 1'b0 : head[0];

  // Saturating statistics; clear_stats wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      drop_cnt    <= '0;
      glitch_cnt  <= '0;
      drop_sticky <= 1'b0;
    end else begin
      if (drop && drop_cnt != 8'hFF)     drop_cnt   <= drop_cnt + 1'b1;
      if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 1'b1;
      if (drop)                          drop_sticky <= 1'b1;
    end
  end

endmodule
